uart_tx_fifo: RTL and testbench

Memory-mapped transmit buffer between the CPU data bus and the `uart_tx` serializer. The CPU writes bytes faster than the line can send them. This block queues those bytes in a FIFO and launches each one into `uart_tx` with a single-cycle `tx_start` pulse once the serializer is idle. It replaces the direct `data_mem_write & cs_uart & !uart_tx_busy` start path, so CPU writes are no longer silently lost while the UART is busy.

---
 rtl/uart_tx_fifo.sv | 164 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: memory-mapped transmit queue in front of the uart_tx serializer.
// CPU stores to DATA are queued; a small launch FSM hands one byte at a time to
// uart_tx with a single-cycle tx_start once the serializer is idle.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for a queued byte and an idle serializer
// WAIT_BUSY  | byte launched; waiting for uart_tx to raise tx_busy (bounded)
// WAIT_DONE  | serializer shifting; waiting for tx_busy to fall
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chip_select,
  input  logic        write_enable,
  input  logic        addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  // Down-counter terminal count at zero gives four cycles in WAIT_BUSY.
  localparam logic [1:0] TMO_LOAD = 2'd3;

  logic [7:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  state_t           state_q, state_d;
  logic [1:0]       tmr_q, tmr_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;

  logic data_wr;
  logic stat_wr;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic active;
  logic [31:0] status;

  // Only bit 3 of a STATUS store and the low byte of a DATA store matter.
  logic unused_wdata;
  assign unused_wdata = ^{write_data[31:8], write_data[2:0]};

  assign data_wr    = chip_select & write_enable & ~addr;
  assign stat_wr    = chip_select & write_enable & addr;
  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  // Fullness uses the pre-edge count, so a push into a full FIFO is dropped
  // even when a pop happens on the same edge.
  assign push       = data_wr & ~fifo_full;
  assign pop        = (state_q == ST_IDLE) & ~fifo_empty & ~tx_busy;
  assign active     = ~fifo_empty | tx_busy | (state_q != ST_IDLE);

  // Next pointers, occupancy and sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (data_wr && fifo_full) begin
      ovf_d = 1'b1;
    end else if (stat_wr && write_data[3]) begin
      ovf_d = 1'b0;
    end
  end

  // Launch FSM: next state, busy-wait timer and registered tx outputs.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          tx_start_d = 1'b1;
          tx_data_d  = mem[rd_ptr_q];
          tmr_d      = TMO_LOAD;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (tmr_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 2'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Register read-back; count field width follows PTR_W, rest zero.
  always_comb begin
    status              = '0;
    status[0]           = active;
    status[1]           = fifo_full;
    status[2]           = fifo_empty;
    status[3]           = ovf_q;
    status[4 +: CNT_W]  = count_q;
    read_data           = (chip_select && addr) ? status : 32'd0;
  end

  // Queue storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= write_data[7:0];
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      tmr_q      <= 2'd0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed bus steps, a simple uart_tx busy model and
// a byte scoreboard checked on every tx_start.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        chip_select = 1'b0;
  logic        write_enable = 1'b0;
  logic        addr = 1'b0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] read_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;

  bit          model_en = 1'b0;
  bit          busy_force = 1'b0;
  int          busy_cnt = 0;
  int          busy_len = 4;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  sb[$];
  int          launch_cnt = 0;
  int          launch_cyc[$];
  bit          prev_start = 1'b0;
  logic [7:0]  mon_exp;

  uart_tx_fifo #(.DEPTH(16), .PTR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .chip_select  (chip_select),
    .write_enable (write_enable),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tx_busy = model_en ? (busy_cnt != 0) : busy_force;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input bit ovf, input bit act);
    logic [31:0] v;
    v = 32'(cnt) << 4;
    v[3] = ovf;
    v[2] = (cnt == 0);
    v[1] = (cnt == 16);
    v[0] = act;
    return v;
  endfunction

  // Monitor + uart_tx model: compare each launched byte against the queue.
  always @(negedge clk) begin
    if (rst) begin
      if (tx_start) begin
        chk("start_one_cycle", {31'd0, prev_start}, 32'd0);
        launch_cnt++;
        launch_cyc.push_back(cyc);
        chk("launch_expected", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) begin
          mon_exp = sb.pop_front();
          chk("tx_data_order", {24'd0, tx_data}, {24'd0, mon_exp});
        end
        if (model_en) busy_cnt = busy_len;
      end else if (busy_cnt != 0) begin
        busy_cnt--;
      end
      prev_start = tx_start;
    end else begin
      prev_start = 1'b0;
      busy_cnt   = 0;
    end
  end

  task automatic bus_wr(input logic a, input logic [31:0] d);
    @(negedge clk);
    chip_select  = 1'b1;
    write_enable = 1'b1;
    addr         = a;
    write_data   = d;
    @(posedge clk);
    if (!a && sb.size() < 16) sb.push_back(d[7:0]);
    #1;
    chip_select  = 1'b0;
    write_enable = 1'b0;
    addr         = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic cs, input logic a, input logic [31:0] exp);
    @(negedge clk);
    chip_select = cs;
    addr        = a;
    #1;
    chk(tag, read_data, exp);
    chip_select = 1'b0;
    addr        = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int k = 0;
    while ((sb.size() != 0 || tx_busy) && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk(tag, sb.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int base;
    int k;
    int gap;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_read_cs0", read_data, 32'd0);
    rd_chk("rst_status", 1'b1, 1'b1, st(0, 0, 0));
    rd_chk("data_reg_reads_zero", 1'b1, 1'b0, 32'd0);
    rd_chk("cs_low_reads_zero", 1'b0, 1'b1, 32'd0);

    // Single byte: launch exactly one edge after the write
    model_en = 1'b1;
    bus_wr(1'b0, 32'h0000_0041);
    @(negedge clk);
    chk("single_not_early", {31'd0, tx_start}, 32'd0);
    @(negedge clk);
    chk("single_start", {31'd0, tx_start}, 32'd1);
    chk("single_data", {24'd0, tx_data}, 32'h41);
    @(negedge clk);
    chk("single_start_drop", {31'd0, tx_start}, 32'd0);
    chk("single_data_held", {24'd0, tx_data}, 32'h41);
    wait_drain("single_drain", 50);
    rd_chk("single_status", 1'b1, 1'b1, st(0, 0, 0));

    // Fill to DEPTH with serializer busy, then overflow and clear
    model_en   = 1'b0;
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) bus_wr(1'b0, 32'hA0 + 32'(i));
    rd_chk("fill_full", 1'b1, 1'b1, st(16, 0, 1));
    bus_wr(1'b0, 32'h0000_00EE);
    rd_chk("fill_ovf", 1'b1, 1'b1, st(16, 1, 1));
    bus_wr(1'b1, 32'h0000_0007);
    rd_chk("ovf_kept_bit3_zero", 1'b1, 1'b1, st(16, 1, 1));
    bus_wr(1'b1, 32'h0000_0008);
    rd_chk("ovf_cleared", 1'b1, 1'b1, st(16, 0, 1));
    @(negedge clk);
    model_en = 1'b1;
    wait_drain("fill_drain", 400);
    rd_chk("fill_drained_status", 1'b1, 1'b1, st(0, 0, 0));

    // Ordering and pointer wrap with a consuming serializer
    for (int i = 0; i < 20; i++) begin
      bus_wr(1'b0, 32'(i));
      repeat (3) @(negedge clk);
    end
    wait_drain("wrap_drain", 400);
    rd_chk("wrap_status", 1'b1, 1'b1, st(0, 0, 0));

    // Simultaneous push and pop at count=3
    @(negedge clk);
    model_en   = 1'b0;
    busy_force = 1'b1;
    bus_wr(1'b0, 32'h51);
    bus_wr(1'b0, 32'h52);
    bus_wr(1'b0, 32'h53);
    rd_chk("pp_count3", 1'b1, 1'b1, st(3, 0, 1));
    @(negedge clk);
    model_en     = 1'b1;
    chip_select  = 1'b1;
    write_enable = 1'b1;
    addr         = 1'b0;
    write_data   = 32'h54;
    @(posedge clk);
    if (sb.size() < 16) sb.push_back(8'h54);
    #1;
    chip_select  = 1'b0;
    write_enable = 1'b0;
    rd_chk("pp_count_unchanged", 1'b1, 1'b1, st(3, 0, 1));
    wait_drain("pp_drain", 200);

    // Busy timeout: serializer never acknowledges
    model_en   = 1'b0;
    busy_force = 1'b0;
    base = launch_cnt;
    bus_wr(1'b0, 32'h61);
    bus_wr(1'b0, 32'h62);
    k = 0;
    while (launch_cnt < base + 2 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_relaunch", {31'd0, (launch_cnt >= base + 2)}, 32'd1);
    if (launch_cnt >= base + 2) begin
      gap = launch_cyc[base + 1] - launch_cyc[base];
      chk("timeout_gap", {31'd0, (gap >= 4 && gap <= 6)}, 32'd1);
    end
    repeat (12) @(negedge clk);
    rd_chk("timeout_idle_status", 1'b1, 1'b1, st(0, 0, 0));

    // Async reset with a launch in flight
    busy_force = 1'b1;
    for (int i = 0; i < 6; i++) bus_wr(1'b0, 32'h70 + 32'(i));
    rd_chk("rst_pre_count", 1'b1, 1'b1, st(6, 0, 1));
    @(negedge clk);
    busy_force = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_inflight_start", {31'd0, tx_start}, 32'd1);
    chip_select = 1'b1;
    addr        = 1'b1;
    rst         = 1'b0;
    #1;
    chk("rst_async_start", {31'd0, tx_start}, 32'd0);
    chk("rst_async_status", read_data, st(0, 0, 0));
    sb.delete();
    chip_select = 1'b0;
    addr        = 1'b0;
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    base = launch_cnt;
    repeat (12) @(negedge clk);
    chk("rst_no_launch", launch_cnt, base);
    bus_wr(1'b0, 32'h77);
    repeat (3) @(negedge clk);
    chk("rst_new_launch", launch_cnt, base + 1);
    repeat (12) @(negedge clk);
    rd_chk("final_status", 1'b1, 1'b1, st(0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
